// File: rtl/multicycle_core_if.sv
// multicycle_core_if
//   Bundles the core's instruction-memory and data-memory signals.
//   master : the core (drives PC and the data-memory side, consumes instr/dReadData)
//   slave  : the memory subsystem (returns instr and dReadData)
//
// Timing contract (there is no valid/ready pair on this bus):
//   instr      : registered read of PC, valid from ID through WB.
//   dReadData  : registered read of dAddress, valid in WB.
//   MemWrite   : the memory writes dWriteData at the rising edge that ends MEM.
//   MemRead    : qualifies dAddress in MEM for a load.
interface multicycle_core_if;
   logic [31:0] instr;
   logic [31:0] dReadData;
   logic [31:0] PC;
   logic [31:0] dAddress;
   logic [31:0] dWriteData;
   logic [31:0] WriteBackData;
   logic        MemRead;
   logic        MemWrite;

   modport master (
      input  instr, dReadData,
      output PC, dAddress, dWriteData, WriteBackData, MemRead, MemWrite
   );

   modport slave (
      output instr, dReadData,
      input  PC, dAddress, dWriteData, WriteBackData, MemRead, MemWrite
   );
endinterface

// File: rtl/multicycle_core.sv
// multicycle_core
//   Five-state (IF, ID, EX, MEM, WB) RV32I-subset core with a 32x32 register
//   file, ALU, immediate generator and PC logic.
// Ports:
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   bus       : memory-side signals (multicycle_core_if.master)
//   state_dbg : current FSM state, for observation only
module multicycle_core #(
   parameter logic [31:0] INITIAL_PC = 32'h0040_0000
) (
   input  logic                      clk,
   input  logic                      rst,
   multicycle_core_if.master         bus,
   output logic [2:0]                state_dbg
);

   localparam logic [2:0] S_IF  = 3'd0;
   localparam logic [2:0] S_ID  = 3'd1;
   localparam logic [2:0] S_EX  = 3'd2;
   localparam logic [2:0] S_MEM = 3'd3;
   localparam logic [2:0] S_WB  = 3'd4;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   logic [2:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] rf_q [32];
   logic [31:0] rf_d [32];
   logic [31:0] rs1_val_q, rs1_val_d;
   logic [31:0] rs2_val_q, rs2_val_d;
   logic [31:0] imm_q, imm_d;
   logic [31:0] alu_q, alu_d;
   logic        zero_q, zero_d;

   // Decode straight from instr, which is stable from ID through WB.
   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic        alt;
   logic        is_r, is_i, is_lw, is_sw, is_beq, writes_rd;
   logic [31:0] imm_i, imm_s, imm_b;
   logic [31:0] alu_b, alu_res, wb_data;
   logic signed [31:0] alu_a_s;

   assign opcode    = bus.instr[6:0];
   assign rd        = bus.instr[11:7];
   assign funct3    = bus.instr[14:12];
   assign rs1       = bus.instr[19:15];
   assign rs2       = bus.instr[24:20];
   assign alt       = bus.instr[30];
   assign is_r      = (opcode == OP_R);
   assign is_i      = (opcode == OP_I);
   assign is_lw     = (opcode == OP_LOAD)   && (funct3 == 3'b010);
   assign is_sw     = (opcode == OP_STORE)  && (funct3 == 3'b010);
   assign is_beq    = (opcode == OP_BRANCH) && (funct3 == 3'b000);
   assign writes_rd = is_r || is_i || is_lw;

   assign imm_i = {{20{bus.instr[31]}}, bus.instr[31:20]};
   assign imm_s = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
   assign imm_b = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                   bus.instr[30:25], bus.instr[11:8], 1'b0};

   // ALU: R-type and beq use rs2, everything else uses the immediate.
   assign alu_b   = (is_r || is_beq) ? rs2_val_q : imm_q;
   assign alu_a_s = rs1_val_q;

   always_comb begin
      alu_res = rs1_val_q + alu_b;
      if (is_beq) begin
         alu_res = rs1_val_q - alu_b;
      end else if (is_r || is_i) begin
         case (funct3)
            // instr[30] selects sub only for R-type; addi has no subtract form.
            3'b000:  alu_res = (is_r && alt) ? rs1_val_q - alu_b : rs1_val_q + alu_b;
            3'b001:  alu_res = rs1_val_q << alu_b[4:0];
            3'b010:  alu_res = {31'd0, (alu_a_s < $signed(alu_b))};
            3'b011:  alu_res = {31'd0, (rs1_val_q < alu_b)};
            3'b100:  alu_res = rs1_val_q ^ alu_b;
            3'b101:  alu_res = alt ? 32'($unsigned(alu_a_s >>> alu_b[4:0]))
                                   : rs1_val_q >> alu_b[4:0];
            3'b110:  alu_res = rs1_val_q | alu_b;
            default: alu_res = rs1_val_q & alu_b;
         endcase
      end
   end

   assign wb_data = is_lw ? bus.dReadData : alu_q;

   always_comb begin
      state_d   = S_IF;
      pc_d      = pc_q;
      rf_d      = rf_q;
      rs1_val_d = rs1_val_q;
      rs2_val_d = rs2_val_q;
      imm_d     = imm_q;
      alu_d     = alu_q;
      zero_d    = zero_q;
      case (state_q)
         S_IF: state_d = S_ID;
         S_ID: begin
            state_d   = S_EX;
            rs1_val_d = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
            rs2_val_d = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
            imm_d     = is_sw ? imm_s : (is_beq ? imm_b : imm_i);
         end
         S_EX: begin
            state_d = S_MEM;
            alu_d   = alu_res;
            zero_d  = (alu_res == 32'd0);
         end
         S_MEM: state_d = S_WB;
         S_WB: begin
            state_d = S_IF;
            pc_d    = (is_beq && zero_q) ? pc_q + imm_q : pc_q + 32'd4;
            if (writes_rd && (rd != 5'd0)) begin
               rf_d[rd] = wb_data;
            end
         end
         default: state_d = S_IF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IF;
         pc_q      <= INITIAL_PC;
         for (int i = 0; i < 32; i++) begin
            rf_q[i] <= 32'd0;
         end
         rs1_val_q <= 32'd0;
         rs2_val_q <= 32'd0;
         imm_q     <= 32'd0;
         alu_q     <= 32'd0;
         zero_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         rf_q      <= rf_d;
         rs1_val_q <= rs1_val_d;
         rs2_val_q <= rs2_val_d;
         imm_q     <= imm_d;
         alu_q     <= alu_d;
         zero_q    <= zero_d;
      end
   end

   // Strobes are gated by rst so a reset landing in MEM cannot write memory.
   assign bus.MemRead       = !rst && (state_q == S_MEM) && is_lw;
   assign bus.MemWrite      = !rst && (state_q == S_MEM) && is_sw;
   assign bus.PC            = pc_q;
   assign bus.dAddress      = alu_q;
   assign bus.dWriteData    = rs2_val_q;
   assign bus.WriteBackData = rst ? 32'd0 : wb_data;
   assign state_dbg         = state_q;

endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core
//   Drives multicycle_core with an instruction/data memory model and checks
//   bus outputs every cycle against an instruction-level reference model.
module tb_multicycle_core;

   localparam logic [31:0] INIT_PC = 32'h0040_0000;

   logic       clk;
   logic       rst;
   logic [2:0] state_dbg;
   int         n_tests;
   int         n_fail;

   multicycle_core_if bus ();

   multicycle_core #(.INITIAL_PC(INIT_PC)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- memories (hardware side) ----------------
   logic [31:0] imem [128];
   logic [31:0] dmem [128];

   always @(posedge clk) begin
      bus.instr     <= imem[bus.PC[8:2]];
      bus.dReadData <= dmem[bus.dAddress[8:2]];
      if (bus.MemWrite) begin
         dmem[bus.dAddress[8:2]] <= bus.dWriteData;
      end
   end

   // ---------------- reference model state ----------------
   logic [31:0] m_regs [32];
   logic [31:0] m_mem  [128];
   logic [31:0] m_pc;

   // ---------------- encoders ----------------
   function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2_f, logic [4:0] rs1_f,
                                         logic [2:0] f3, logic [4:0] rd_f);
      return {f7, rs2_f, rs1_f, f3, rd_f, 7'h33};
   endfunction

   function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1_f, logic [2:0] f3,
                                         logic [4:0] rd_f, logic [6:0] op);
      return {imm, rs1_f, f3, rd_f, op};
   endfunction

   function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2_f, logic [4:0] rs1_f);
      return {imm[11:5], rs2_f, rs1_f, 3'b010, imm[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2_f, logic [4:0] rs1_f,
                                         logic [2:0] f3);
      return {imm[12], imm[10:5], rs2_f, rs1_f, f3, imm[4:1], imm[11], 7'h63};
   endfunction

   // ---------------- random instruction generator ----------------
   function automatic logic [2:0] rand_f3();
      logic [2:0] f3;
      f3 = 3'($urandom_range(0, 7));
      if (f3 == 3'd3) f3 = 3'd0;   // sltu/sltiu are not part of the subset
      return f3;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [2:0]  f3;
      logic [4:0]  ra, rb, rdx;
      logic [11:0] imm;
      logic [12:0] boff;
      ra  = 5'($urandom_range(0, 7));
      rb  = 5'($urandom_range(0, 7));
      rdx = 5'($urandom_range(0, 7));
      f3  = rand_f3();
      case ($urandom_range(0, 9))
         0, 1, 2: return enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                               rb, ra, f3, rdx);
         3, 4, 5: begin
            imm = 12'($urandom_range(0, 4095));
            if (f3 == 3'd1) imm = {7'h00, imm[4:0]};
            if (f3 == 3'd5) imm = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, imm[4:0]};
            return enc_i(imm, ra, f3, rdx, 7'h13);
         end
         6: return enc_i(12'($urandom_range(0, 127) * 4), 5'd0, 3'b010, rdx, 7'h03);
         7: return enc_s(12'($urandom_range(0, 127) * 4), rb, 5'd0);
         8: begin
            boff = 13'(($urandom_range(0, 8) - 4) * 4);
            if (boff == 13'd0) boff = 13'd8;
            return enc_b(boff, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'b000);
         end
         default: begin
            case ($urandom_range(0, 2))
               0:       return 32'h0000_000F;                       // fence
               1:       return {20'h12345, rdx, 7'h37};             // lui
               default: return enc_b(13'd8, 5'd1, 5'd1, 3'b001);    // bne
            endcase
         end
      endcase
   endfunction

   // ---------------- reference model ----------------
   function automatic logic [31:0] ref_alu(logic [2:0] f3, logic alt_op, logic [31:0] a, logic [31:0] b);
      logic signed [31:0] sa;
      sa = a;
      case (f3)
         3'd0:    return alt_op ? a - b : a + b;
         3'd1:    return a << b[4:0];
         3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd4:    return a ^ b;
         3'd5:    return alt_op ? 32'(sa >>> b[4:0]) : a >> b[4:0];
         3'd6:    return a | b;
         default: return a & b;
      endcase
   endfunction

   task automatic model_exec(input logic [31:0] ins, output bit wr, output bit ld, output bit st,
                             output logic [31:0] wb, output logic [31:0] addr,
                             output logic [31:0] wdata, output logic [31:0] npc);
      logic [31:0] a, b, immi, imms, immb;
      logic [2:0]  f3;
      f3   = ins[14:12];
      a    = m_regs[ins[19:15]];
      b    = m_regs[ins[24:20]];
      immi = 32'($signed(ins[31:20]));
      imms = 32'($signed({ins[31:25], ins[11:7]}));
      immb = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      wr = 0; ld = 0; st = 0; wb = 0; addr = 0; wdata = 0;
      npc = m_pc + 32'd4;
      case (ins[6:0])
         7'h33: begin wr = 1; wb = ref_alu(f3, ins[30], a, b); end
         7'h13: begin wr = 1; wb = ref_alu(f3, ins[30] && f3 == 3'd5, a, immi); end
         7'h03: if (f3 == 3'd2) begin
            wr = 1; ld = 1; addr = a + immi; wb = m_mem[addr[8:2]];
         end
         7'h23: if (f3 == 3'd2) begin
            st = 1; addr = a + imms; wdata = b;
         end
         7'h63: if (f3 == 3'd0 && a == b) npc = m_pc + immb;
         default: ;
      endcase
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at the falling edge of an IF cycle; returns at the falling edge of the next IF.
   task automatic run_one();
      logic [31:0] ins, wb, addr, wdata, npc;
      bit          wr, ld, st;
      ins = imem[m_pc[8:2]];
      model_exec(ins, wr, ld, st, wb, addr, wdata, npc);
      for (int c = 0; c < 5; c++) begin
         check("pc", bus.PC, m_pc);
         check("mem_read", {31'd0, bus.MemRead}, {31'd0, (c == 3) && ld});
         check("mem_write", {31'd0, bus.MemWrite}, {31'd0, (c == 3) && st});
         if (c == 3 && (ld || st)) check("d_address", bus.dAddress, addr);
         if (c == 3 && st) check("d_write_data", bus.dWriteData, wdata);
         if (c == 4 && wr) check("write_back_data", bus.WriteBackData, wb);
         @(posedge clk);
         @(negedge clk);
      end
      if (wr && ins[11:7] != 5'd0) m_regs[ins[11:7]] = wb;
      if (st) m_mem[addr[8:2]] = wdata;
      m_pc = npc;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_pc"}, bus.PC, INIT_PC);
      check({tag, "_mem_read"}, {31'd0, bus.MemRead}, 32'd0);
      check({tag, "_mem_write"}, {31'd0, bus.MemWrite}, 32'd0);
      check({tag, "_d_address"}, bus.dAddress, 32'd0);
      check({tag, "_d_write_data"}, bus.dWriteData, 32'd0);
      check({tag, "_write_back_data"}, bus.WriteBackData, 32'd0);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b1;

      for (int i = 0; i < 128; i++) begin
         imem[i]   = rand_instr();
         dmem[i]   = $urandom;
         m_mem[i]  = dmem[i];
      end
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_pc = INIT_PC;

      imem[0]  = enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13);          // addi x1,x0,5
      imem[1]  = enc_i(12'hFFD, 5'd0, 3'd0, 5'd2, 7'h13);        // addi x2,x0,-3
      imem[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);           // add  x3,x1,x2
      imem[3]  = enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd4);           // sub  x4,x2,x1
      imem[4]  = enc_r(7'h00, 5'd1, 5'd2, 3'd2, 5'd5);           // slt  x5,x2,x1
      imem[5]  = enc_i({7'h20, 5'd1}, 5'd2, 3'd5, 5'd6, 7'h13);  // srai x6,x2,1
      imem[6]  = enc_i(12'd28, 5'd2, 3'd5, 5'd7, 7'h13);         // srli x7,x2,28
      imem[7]  = enc_s(12'd8, 5'd1, 5'd0);                       // sw   x1,8(x0)
      imem[8]  = enc_i(12'd8, 5'd0, 3'd2, 5'd8, 7'h03);          // lw   x8,8(x0)
      imem[9]  = enc_b(13'd8, 5'd1, 5'd1, 3'd0);                 // beq  x1,x1,+8
      imem[10] = enc_i(12'd1, 5'd0, 3'd0, 5'd20, 7'h13);         // skipped
      imem[11] = enc_b(13'd8, 5'd2, 5'd1, 3'd0);                 // beq  x1,x2,+8
      imem[12] = enc_i(12'd7, 5'd0, 3'd0, 5'd0, 7'h13);          // addi x0,x0,7
      imem[13] = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd9);           // add  x9,x0,x0

      // reset
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check_reset_state("reset");
      rst = 1'b0;

      // directed program (index 10 is branched over)
      for (int i = 0; i < 13; i++) run_one();

      // random program
      for (int i = 0; i < 60; i++) run_one();

      // self-branch: PC must stay put
      imem[m_pc[8:2]] = enc_b(13'd0, 5'd0, 5'd0, 3'd0);
      for (int i = 0; i < 3; i++) run_one();

      // reset landing in EX of a register-writing instruction
      imem[m_pc[8:2]] = enc_i(12'd99, 5'd0, 3'd0, 5'd10, 7'h13);  // addi x10,x0,99
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_state("mid_reset");
      rst = 1'b0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_pc = INIT_PC;

      imem[0] = enc_r(7'h00, 5'd1, 5'd10, 3'd0, 5'd12);            // add x12,x10,x1 -> 0
      for (int i = 0; i < 25; i++) run_one();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
